// File: rtl/vin_pixel_packer.sv
// ---------------------------------------------------------------------------
// vin_pixel_packer
//
// Packs the pixel-clock video stream from the FPD-Link input stage (two Y4
// pixels per clock) into OUT_WIDTH-bit words. Each word is tagged with
// start-of-frame and end-of-line flags and buffered in a small FIFO. The FIFO
// head is offered to the frame-buffer write path on a valid/ready interface.
// The block also enforces the active window and reports short/long lines and
// FIFO overflow.
//
// Ports
//   clk          pixel clock, the only clock
//   rst_n        asynchronous active-low reset (released synchronously upstream)
//   v_vsync      vertical sync, active high; its rising edge starts a frame
//   v_hsync      horizontal sync; unused, line boundaries come from DE edges
//   v_de         data enable, one pixel pair per high cycle
//   v_pixel      {even Y4, odd Y4}
//   out_data     packed word, pair k in bits [8k+7:8k]
//   out_sof      head word is the first word of a frame
//   out_eol      head word is the last word of a line
//   out_valid    FIFO head valid
//   out_ready    consumer accepts the head word this cycle
//   overflow     sticky, a completed word found the FIFO full
//   line_err     one-cycle pulse, the line just ended had the wrong length
//   frame_count  number of accepted frame starts, wraps at 16 bits
// ---------------------------------------------------------------------------
module vin_pixel_packer #(
  parameter int OUT_WIDTH  = 64,
  parameter int H_PAIRS    = 800,
  parameter int V_LINES    = 1200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 v_vsync,
  input  logic                 v_hsync,
  input  logic                 v_de,
  input  logic [7:0]           v_pixel,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sof,
  output logic                 out_eol,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow,
  output logic                 line_err,
  output logic [15:0]          frame_count
);

  localparam int PPW = OUT_WIDTH / 8;
  localparam int XW  = $clog2(H_PAIRS + 1);
  localparam int YW  = $clog2(V_LINES + 1);
  localparam int SW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2,
    S_DROP   = 2'd3
  } state_t;

  state_t r_state, w_state_next;

  logic                 r_vsync_d;
  logic [XW-1:0]        r_x;
  logic [YW-1:0]        r_y;
  logic [SW-1:0]        r_slot;
  logic [OUT_WIDTH-1:0] r_pack;
  logic                 r_sof_pend;
  logic                 r_long;
  logic                 r_overflow;
  logic                 r_line_err;
  logic [15:0]          r_frame_count;

  logic [OUT_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic                 r_mem_sof  [FIFO_DEPTH];
  logic                 r_mem_eol  [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;

  logic                 w_vs_rise;
  logic                 w_take;
  logic                 w_in_range;
  logic                 w_word_full;
  logic                 w_line_end;
  logic                 w_flush;
  logic                 w_push_req;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_drop;
  logic                 w_push;
  logic                 w_push_eol;
  logic                 w_line_err_next;
  logic [OUT_WIDTH-1:0] w_pack_next;
  logic [OUT_WIDTH-1:0] w_push_data;
  logic                 w_unused;

  assign w_unused  = v_hsync;
  assign w_vs_rise = v_vsync & ~r_vsync_d;

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // ---- next-state logic ----
  always_comb begin
    w_state_next = r_state;
    if (w_vs_rise) begin
      w_state_next = S_WAIT;
    end else begin
      case (r_state)
        S_IDLE:   w_state_next = S_IDLE;
        S_WAIT:   if (w_drop) w_state_next = S_DROP;
                  else if (w_take) w_state_next = S_ACTIVE;
        S_ACTIVE: if (w_drop) w_state_next = S_DROP;
                  else if (w_line_end) w_state_next = S_WAIT;
        S_DROP:   w_state_next = S_DROP;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // ---- output / control decode ----
  // A vsync rising edge overrides everything, so a line in progress is
  // abandoned without a push or an error.
  always_comb begin
    w_take      = 1'b0;
    w_line_end  = 1'b0;
    w_pack_next = r_pack;
    if (!w_vs_rise) begin
      w_take     = v_de && ((r_state == S_ACTIVE) ||
                            ((r_state == S_WAIT) && (r_y < YW'(V_LINES))));
      w_line_end = !v_de && (r_state == S_ACTIVE);
    end
    w_in_range  = (r_x < XW'(H_PAIRS));
    w_word_full = w_take && w_in_range && (r_slot == SW'(PPW - 1));
    // Partial words only exist when the line stopped short; their unused
    // slots are already zero because the pack register clears after a push.
    w_flush     = w_line_end && w_in_range && (r_slot != '0);
    w_push_req  = w_word_full || w_flush;
    for (int k = 0; k < PPW; k++) begin
      if (r_slot == SW'(k)) w_pack_next[8*k +: 8] = v_pixel;
    end
    w_push_data = w_word_full ? w_pack_next : r_pack;
    w_push_eol  = w_flush || (r_x == XW'(H_PAIRS - 1));
    w_pop       = (r_count != '0) && out_ready;
    w_full      = (r_count == CW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    w_drop      = w_push_req && w_full && !w_pop;
    w_push      = w_push_req && !w_drop;
    w_line_err_next = w_line_end && ((r_x != XW'(H_PAIRS)) || r_long);
  end

  // ---- line / frame tracking and packing ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d     <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_slot        <= '0;
      r_pack        <= '0;
      r_sof_pend    <= 1'b0;
      r_long        <= 1'b0;
      r_overflow    <= 1'b0;
      r_line_err    <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_vsync_d  <= v_vsync;
      r_line_err <= w_line_err_next;
      if (w_drop) r_overflow <= 1'b1;
      if (w_push) r_sof_pend <= 1'b0;
      if (w_vs_rise) begin
        r_x           <= '0;
        r_y           <= '0;
        r_slot        <= '0;
        r_pack        <= '0;
        r_long        <= 1'b0;
        r_sof_pend    <= 1'b1;
        r_frame_count <= r_frame_count + 16'd1;
      end else if (w_take) begin
        if (w_in_range) begin
          r_x    <= r_x + XW'(1);
          r_slot <= (r_slot == SW'(PPW - 1)) ? '0 : r_slot + SW'(1);
          r_pack <= w_word_full ? '0 : w_pack_next;
        end else begin
          r_long <= 1'b1;
        end
      end else if (w_line_end) begin
        r_x    <= '0;
        r_y    <= r_y + YW'(1);
        r_slot <= '0;
        r_pack <= '0;
        r_long <= 1'b0;
      end
    end
  end

  // ---- output FIFO ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; the head is masked by valid instead.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= w_push_data;
      r_mem_sof[r_wptr]  <= r_sof_pend;
      r_mem_eol[r_wptr]  <= w_push_eol;
    end
  end

  assign out_valid   = (r_count != '0);
  assign out_data    = out_valid ? r_mem_data[r_rptr] : '0;
  assign out_sof     = out_valid & r_mem_sof[r_rptr];
  assign out_eol     = out_valid & r_mem_eol[r_rptr];
  assign overflow    = r_overflow;
  assign line_err    = r_line_err;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_vin_pixel_packer.sv
module tb_vin_pixel_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_vsync, v_hsync, v_de, out_ready;
  logic [7:0]  v_pixel;
  logic [63:0] out_data, out_data2;
  logic        out_sof, out_eol, out_valid, overflow, line_err;
  logic        out_sof2, out_eol2, out_valid2, overflow2, line_err2;
  logic [15:0] frame_count, frame_count2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] q_data [$];
  bit          q_sof  [$];
  bit          q_eol  [$];
  bit          q2_eol [$];
  int          n_lerr  = 0;
  int          n_lerr2 = 0;

  always #5 clk = ~clk;

  vin_pixel_packer u_dut (
    .clk(clk), .rst_n(rst_n), .v_vsync(v_vsync), .v_hsync(v_hsync), .v_de(v_de),
    .v_pixel(v_pixel), .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .line_err(line_err), .frame_count(frame_count)
  );

  vin_pixel_packer #(.V_LINES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .v_vsync(v_vsync), .v_hsync(v_hsync), .v_de(v_de),
    .v_pixel(v_pixel), .out_data(out_data2), .out_sof(out_sof2), .out_eol(out_eol2),
    .out_valid(out_valid2), .out_ready(out_ready), .overflow(overflow2),
    .line_err(line_err2), .frame_count(frame_count2)
  );

  // Transfers complete on the following rising edge; record them here.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_sof.push_back(out_sof);
      q_eol.push_back(out_eol);
    end
    if (out_valid2 && out_ready) q2_eol.push_back(out_eol2);
    if (line_err)  n_lerr  = n_lerr + 1;
    if (line_err2) n_lerr2 = n_lerr2 + 1;
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_vsync();
    v_vsync = 1'b1; v_hsync = 1'b1;
    idle(3);
    v_vsync = 1'b0; v_hsync = 1'b0;
    idle(4);
  endtask

  // Leaves DE low right after the last pair; the caller decides the gap.
  task automatic send_line(input int n);
    for (int i = 0; i < n; i++) begin
      v_de = 1'b1;
      v_pixel = i[7:0];
      @(posedge clk); #1;
    end
    v_de = 1'b0;
    v_pixel = 8'h00;
  endtask

  task automatic test_reset();
    int b;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    n_checks++; if ({out_sof, out_eol, overflow, line_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {out_sof, out_eol, overflow, line_err}); end
    n_checks++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frames got %0d want 0", frame_count); end
    // DE before any vsync must be ignored.
    b = q_data.size();
    send_line(16);
    idle(6);
    n_checks++; if (q_data.size() - b !== 0) begin n_fail++; $display("FAIL idle_ignores_de got %0d words want 0", q_data.size() - b); end
    n_checks++; if (n_lerr !== 0) begin n_fail++; $display("FAIL idle_line_err got %0d want 0", n_lerr); end
  endtask

  task automatic test_nominal();
    int b, l, neol, nsof;
    out_ready = 1'b1;
    b = q_data.size(); l = n_lerr;
    send_vsync();
    for (int ln = 0; ln < 3; ln++) begin send_line(800); idle(10); end
    idle(10);
    n_checks++; if (q_data.size() - b !== 300) begin n_fail++; $display("FAIL nom_words got %0d want 300", q_data.size() - b); end
    if (q_data.size() - b >= 300) begin
      n_checks++; if (q_data[b] !== 64'h0706050403020100) begin n_fail++; $display("FAIL nom_word0 got %h want 0706050403020100", q_data[b]); end
      n_checks++; if (q_sof[b] !== 1'b1) begin n_fail++; $display("FAIL nom_sof0 got %b want 1", q_sof[b]); end
      n_checks++; if (q_data[b+1] !== 64'h0f0e0d0c0b0a0908) begin n_fail++; $display("FAIL nom_word1 got %h want 0f0e0d0c0b0a0908", q_data[b+1]); end
      n_checks++; if (q_data[b+99] !== 64'h1f1e1d1c1b1a1918) begin n_fail++; $display("FAIL nom_word99 got %h want 1f1e1d1c1b1a1918", q_data[b+99]); end
      n_checks++; if ({q_eol[b+99], q_eol[b+199], q_eol[b+299]} !== 3'b111) begin n_fail++; $display("FAIL nom_eol_pos got %b want 111", {q_eol[b+99], q_eol[b+199], q_eol[b+299]}); end
      neol = 0; nsof = 0;
      for (int i = 0; i < 300; i++) begin neol += q_eol[b+i]; nsof += q_sof[b+i]; end
      n_checks++; if (neol !== 3) begin n_fail++; $display("FAIL nom_eol_count got %0d want 3", neol); end
      n_checks++; if (nsof !== 1) begin n_fail++; $display("FAIL nom_sof_count got %0d want 1", nsof); end
    end
    n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL nom_frames got %0d want 1", frame_count); end
    n_checks++; if (n_lerr - l !== 0) begin n_fail++; $display("FAIL nom_line_err got %0d want 0", n_lerr - l); end
  endtask

  task automatic test_short_line();
    int b, l;
    b = q_data.size(); l = n_lerr;
    send_vsync();
    send_line(797);
    n_checks++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL short_err_early got %b want 0", line_err); end
    idle(1);
    n_checks++; if (line_err !== 1'b1) begin n_fail++; $display("FAIL short_err_pulse got %b want 1", line_err); end
    idle(1);
    n_checks++; if (line_err !== 1'b0) begin n_fail++; $display("FAIL short_err_width got %b want 0", line_err); end
    idle(10);
    n_checks++; if (q_data.size() - b !== 100) begin n_fail++; $display("FAIL short_words got %0d want 100", q_data.size() - b); end
    if (q_data.size() - b >= 100) begin
      n_checks++; if (q_data[b+99] !== 64'h0000001c1b1a1918) begin n_fail++; $display("FAIL short_last got %h want 0000001c1b1a1918", q_data[b+99]); end
      n_checks++; if (q_eol[b+99] !== 1'b1) begin n_fail++; $display("FAIL short_last_eol got %b want 1", q_eol[b+99]); end
      n_checks++; if (q_eol[b+98] !== 1'b0) begin n_fail++; $display("FAIL short_prev_eol got %b want 0", q_eol[b+98]); end
    end
    n_checks++; if (n_lerr - l !== 1) begin n_fail++; $display("FAIL short_err_count got %0d want 1", n_lerr - l); end
    n_checks++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL short_frames got %0d want 2", frame_count); end
  endtask

  task automatic test_long_line();
    int b, l;
    b = q_data.size(); l = n_lerr;
    send_vsync();
    send_line(803);
    idle(12);
    n_checks++; if (q_data.size() - b !== 100) begin n_fail++; $display("FAIL long_words got %0d want 100", q_data.size() - b); end
    if (q_data.size() - b >= 100) begin
      n_checks++; if (q_data[b+99] !== 64'h1f1e1d1c1b1a1918) begin n_fail++; $display("FAIL long_last got %h want 1f1e1d1c1b1a1918", q_data[b+99]); end
      n_checks++; if (q_eol[b+99] !== 1'b1) begin n_fail++; $display("FAIL long_last_eol got %b want 1", q_eol[b+99]); end
    end
    n_checks++; if (n_lerr - l !== 1) begin n_fail++; $display("FAIL long_err_count got %0d want 1", n_lerr - l); end
  endtask

  task automatic test_backpressure();
    int b, l;
    out_ready = 1'b0;
    l = n_lerr;
    send_vsync();
    send_line(36);
    v_de = 1'b1; v_pixel = 8'h24;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL bp_no_ovf_yet got %b want 0", overflow); end
    n_checks++; if (out_data !== 64'h0706050403020100 || out_sof !== 1'b1) begin n_fail++; $display("FAIL bp_head_hold got %h/%b want 0706050403020100/1", out_data, out_sof); end
    for (int i = 36; i < 800; i++) begin
      v_de = 1'b1; v_pixel = i[7:0];
      @(posedge clk); #1;
    end
    v_de = 1'b0;
    idle(10);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow got %b want 1", overflow); end
    n_checks++; if (out_data !== 64'h0706050403020100 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head_stable got %h/%b", out_data, out_valid); end
    n_checks++; if (n_lerr - l !== 0) begin n_fail++; $display("FAIL bp_drop_err got %0d want 0", n_lerr - l); end
    b = q_data.size();
    out_ready = 1'b1;
    idle(8);
    send_vsync();
    send_line(800);
    idle(12);
    n_checks++; if (q_data.size() - b !== 104) begin n_fail++; $display("FAIL bp_words got %0d want 104", q_data.size() - b); end
    if (q_data.size() - b >= 104) begin
      n_checks++; if (q_data[b+3] !== 64'h1f1e1d1c1b1a1918) begin n_fail++; $display("FAIL bp_old_word3 got %h want 1f1e1d1c1b1a1918", q_data[b+3]); end
      n_checks++; if (q_data[b+4] !== 64'h0706050403020100 || q_sof[b+4] !== 1'b1) begin n_fail++; $display("FAIL bp_new_sof got %h/%b want 0706050403020100/1", q_data[b+4], q_sof[b+4]); end
    end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_sticky got %b want 1", overflow); end
    n_checks++; if (frame_count !== 16'd5) begin n_fail++; $display("FAIL bp_frames got %0d want 5", frame_count); end
  endtask

  task automatic test_vlines();
    int b, l, neol;
    b = q2_eol.size(); l = n_lerr2;
    send_vsync();
    for (int ln = 0; ln < 3; ln++) begin send_line(800); idle(10); end
    idle(6);
    n_checks++; if (q2_eol.size() - b !== 200) begin n_fail++; $display("FAIL vl_words got %0d want 200", q2_eol.size() - b); end
    neol = 0;
    for (int i = b; i < q2_eol.size(); i++) neol += q2_eol[i];
    n_checks++; if (neol !== 2) begin n_fail++; $display("FAIL vl_eol_count got %0d want 2", neol); end
    n_checks++; if (n_lerr2 - l !== 0) begin n_fail++; $display("FAIL vl_line_err got %0d want 0", n_lerr2 - l); end
    n_checks++; if (frame_count2 !== 16'd6) begin n_fail++; $display("FAIL vl_frames got %0d want 6", frame_count2); end
    b = q2_eol.size();
    send_vsync();
    send_line(800);
    idle(12);
    n_checks++; if (q2_eol.size() - b !== 100) begin n_fail++; $display("FAIL vl_restart_words got %0d want 100", q2_eol.size() - b); end
    n_checks++; if (frame_count2 !== 16'd7) begin n_fail++; $display("FAIL vl_restart_frames got %0d want 7", frame_count2); end
  endtask

  task automatic test_reset_midline();
    int b, l;
    out_ready = 1'b0;
    send_vsync();
    send_line(26);
    v_de = 1'b1; v_pixel = 8'h1a;
    n_checks++; if (out_valid !== 1'b1 || frame_count !== 16'd8) begin n_fail++; $display("FAIL rm_pre got valid %b frames %0d want 1/8", out_valid, frame_count); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 64'h0 || out_sof !== 1'b0) begin n_fail++; $display("FAIL rm_async got %b/%h/%b want 0/0/0", out_valid, out_data, out_sof); end
    n_checks++; if (overflow !== 1'b0 || frame_count !== 16'd0) begin n_fail++; $display("FAIL rm_status got %b/%0d want 0/0", overflow, frame_count); end
    idle(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    b = q_data.size(); l = n_lerr;
    send_line(100);
    idle(10);
    n_checks++; if (q_data.size() - b !== 0 || n_lerr - l !== 0) begin n_fail++; $display("FAIL rm_ignore got %0d words %0d errs want 0/0", q_data.size() - b, n_lerr - l); end
    send_vsync();
    send_line(800);
    idle(12);
    n_checks++; if (q_data.size() - b !== 100) begin n_fail++; $display("FAIL rm_after_words got %0d want 100", q_data.size() - b); end
    if (q_data.size() - b >= 1) begin
      n_checks++; if (q_sof[b] !== 1'b1 || q_data[b] !== 64'h0706050403020100) begin n_fail++; $display("FAIL rm_after_word0 got %h/%b", q_data[b], q_sof[b]); end
    end
    n_checks++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL rm_after_frames got %0d want 1", frame_count); end
  endtask

  initial begin
    rst_n = 1'b0; v_vsync = 1'b0; v_hsync = 1'b0; v_de = 1'b0;
    v_pixel = 8'h00; out_ready = 1'b1;
    idle(4);
    rst_n = 1'b1;
    idle(2);
    test_reset();
    test_nominal();
    test_short_line();
    test_long_line();
    test_backpressure();
    test_vlines();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vin_pixel_packer.md
Name: vin_pixel_packer

Overview:
- Downstream consumer of the FPD-Link video input stage's pixel-clock output stream: v_vsync, v_hsync, v_de, and 2 Y4 pixels per clock.
- Packs pixel pairs into OUT_WIDTH-bit words, tags start-of-frame and end-of-line, and buffers the words in a small FIFO.
- Presents the words on a valid/ready interface toward the frame-buffer write path.
- Enforces the active window, and flags short/long lines and FIFO overflow.

Parameters:
- OUT_WIDTH, 64: output word width; must be a multiple of 8. PPW = OUT_WIDTH/8 pixel pairs per word.
- H_PAIRS, 800: expected DE-high pairs per line (1600 pixels); must be a multiple of PPW.
- V_LINES, 1200: active lines accepted per frame.
- FIFO_DEPTH, 4: output FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  pixel clock (v_pclk of the input stage); the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- v_vsync  in  1  vertical sync, active high, masked upstream during the first frames.
- v_hsync  in  1  horizontal sync, active high.
- v_de  in  1  data enable.
- v_pixel  in  8  {even Y4, odd Y4}.
- out_data  out  OUT_WIDTH  packed pixels; pair k occupies bits [8k+7:8k].
- out_sof  out  1  first word of the frame.
- out_eol  out  1  last word of a line.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid & out_ready.
- overflow  out  1  sticky; FIFO was full when a word completed.
- line_err  out  1  one-cycle pulse; line length ≠ H_PAIRS.
- frame_count  out  16  accepted frame starts, wraps at 65535→0.

Behaviour:
- Reset (async assert, sync release): state IDLE, FIFO empty, out_valid=0, out_sof=0, out_eol=0, out_data=0, overflow=0, line_err=0, frame_count=0, x/y counters 0, pack register 0.
- vsync rising edge (registered previous value) from any state:
  - state → WAIT_LINE, y=0, x=0, pack register cleared, sof_pending=1, frame_count+1.
  - FIFO contents are not flushed.
- IDLE: ignores DE until the first vsync rising edge.
- WAIT_LINE: on v_de=1 with y<V_LINES → ACTIVE; the current pair is captured as pair 0. With y≥V_LINES, DE is ignored.
- ACTIVE, each DE-high cycle:
  - If x<H_PAIRS: pair written at slot x mod PPW and x increments.
  - If x≥H_PAIRS: pair discarded and long flag set.
  - When slot PPW-1 is filled, the word is pushed:
    - sof = sof_pending; sof_pending cleared on push.
    - eol = (x+1 == H_PAIRS).
- ACTIVE, DE falling edge (v_de=0):
  - If x<H_PAIRS and a partial word exists: remaining slots zero-filled, pushed with eol=1.
  - If x<H_PAIRS and no partial word exists: the last pushed word carries no eol; no extra word is generated.
  - line_err pulses if x≠H_PAIRS or the long flag is set.
  - Then y+1, x=0, long flag cleared, state → WAIT_LINE.
- Push latency: the word is visible at the FIFO head the cycle after its last pair is sampled, when the FIFO was empty.
- Simultaneous push and pop on a full FIFO is allowed; the push succeeds.
- Push with the FIFO full and no pop:
  - Word dropped, overflow=1 (sticky until reset), state → DROP.
  - DROP discards all input until the next vsync rising edge.
- out_data, out_sof, and out_eol are stable while out_valid=1 and out_ready=0.
- v_hsync is used only to qualify nothing; line boundaries come from DE edges.
- vsync rising while ACTIVE aborts the line silently: no push, no line_err.

Test Plan:
- Nominal frame, default parameters, out_ready=1, 3 lines of 800 pairs, pair value = x[7:0]:
  - 100 words per line; word0 data 0x0706050403020100 with sof=1.
  - Words 99, 199, 299 have eol=1; frame_count=1; line_err never pulses.
- Short line of 797 pairs:
  - Last word = {24'h0, pairs 792..796}, eol=1.
  - line_err pulses one cycle after DE falls.
- Long line of 803 pairs:
  - Exactly 100 words; extra pairs absent; line_err pulses once.
- Backpressure: out_ready=0 from start of line:
  - 4 words buffered, 5th completion → overflow=1, words dropped until vsync.
  - After the next vsync with out_ready=1, the next frame's word0 has sof=1.
  - overflow stays 1.
- V_LINES=2, 3 lines sent:
  - Third line produces no words; y holds.
  - A new vsync restarts with frame_count incremented.
- rst_n asserted mid-line with 3 words buffered:
  - Outputs go to reset values immediately.
  - DE traffic is ignored until a vsync rising edge.
